// File: rtl/sine_dds.sv
// sine_dds: direct-digital-synthesis sine source, one stereo sample per frame-clock rise.
// Phase accumulator, quarter-wave ROM, sign fold, amplitude scaling and right-channel phase offset.
module sine_dds #(
   parameter int BITSIZE   = 16,
   parameter int PHASESIZE = 24,
   parameter int LUTBITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lrclk,
   input  logic                 enable,
   input  logic [PHASESIZE-1:0] freq_word,
   input  logic [PHASESIZE-1:0] phase_offset,
   input  logic [BITSIZE-1:0]   amplitude,
   output logic [BITSIZE-1:0]   left_chan,
   output logic [BITSIZE-1:0]   right_chan,
   output logic                 sample_valid,
   output logic                 overrun
);

   localparam int ROM_DEPTH = 2 ** LUTBITS;
   localparam int ADDR_W    = LUTBITS + 2;
   localparam int PROD_W    = 2 * BITSIZE + 1;

   localparam logic [2:0] CNT_HOLD = 3'd4;
   localparam logic [2:0] CNT_OUT  = 3'd5;
   localparam logic [2:0] CNT_LAST = 3'd6;

   // pi in Q60 fixed point
   localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

   // round((2^(BITSIZE-1)-1) * sin(pi/2 * (idx+0.5) / 2^LUTBITS)) via a Q60 Taylor series
   function automatic logic [BITSIZE-2:0] rom_value(input int unsigned idx);
      logic [127:0] x;
      logic [127:0] x2;
      logic [127:0] term;
      logic [127:0] acc_pos;
      logic [127:0] acc_neg;
      logic [127:0] scaled;
      x       = (128'(PI_Q60) * 128'(2 * idx + 1)) >> (LUTBITS + 2);
      x2      = (x * x) >> 60;
      term    = x;
      acc_pos = x;
      acc_neg = '0;
      for (int k = 1; k <= 9; k++) begin
         term = ((term * x2) >> 60) / 128'(2 * k * (2 * k + 1));
         if (k % 2 == 1) acc_neg = acc_neg + term;
         else            acc_pos = acc_pos + term;
      end
      scaled = (acc_pos - acc_neg) * 128'(2 ** (BITSIZE - 1) - 1) + (128'd1 << 59);
      return (BITSIZE - 1)'(scaled >> 60);
   endfunction

   logic [BITSIZE-2:0] w_rom [ROM_DEPTH];

   generate
      for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
         assign w_rom[gi] = rom_value(gi);
      end
   endgenerate

   logic [2:0]                r_sync;
   logic                      r_tick;
   logic [2:0]                r_cnt;
   logic [PHASESIZE-1:0]      r_phase_acc;
   logic [ADDR_W-1:0]         r_pl;
   logic [ADDR_W-1:0]         r_pr;
   logic [BITSIZE-1:0]        r_amp;
   logic                      r_en;
   logic [LUTBITS-1:0]        r_addr;
   logic                      r_neg_s0;
   logic                      r_neg_s1;
   logic [BITSIZE-2:0]        r_rom_data;
   logic signed [BITSIZE-1:0] r_sgn;
   logic [BITSIZE-1:0]        r_hold_l;
   logic [BITSIZE-1:0]        r_left;
   logic [BITSIZE-1:0]        r_right;
   logic                      r_valid;
   logic                      r_overrun;

   logic                      w_busy;
   logic                      w_accept;
   logic [ADDR_W-1:0]         w_p;
   logic [1:0]                w_q;
   logic [LUTBITS-1:0]        w_idx;
   logic signed [PROD_W-1:0]  w_prod;
   logic [BITSIZE-1:0]        w_scaled;

   assign w_busy   = (r_cnt != 3'd0);
   assign w_accept = r_tick && !w_busy;

   // Left channel uses the address stage on count 1, right channel one clock later
   assign w_p   = (r_cnt == 3'd1) ? r_pl : r_pr;
   assign w_q   = w_p[ADDR_W-1 -: 2];
   assign w_idx = w_q[0] ? ~w_p[LUTBITS-1:0] : w_p[LUTBITS-1:0];

   assign w_prod   = PROD_W'(r_sgn) * $signed(PROD_W'(r_amp));
   assign w_scaled = r_en ? BITSIZE'(w_prod >>> BITSIZE) : '0;

   always_ff @(posedge clk) begin
      r_sync <= {r_sync[1:0], lrclk};
      if (rst) begin
         r_tick      <= 1'b0;
         r_cnt       <= 3'd0;
         r_phase_acc <= '0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
         r_left      <= '0;
         r_right     <= '0;
      end else begin
         r_tick  <= r_sync[1] && !r_sync[2];
         r_valid <= (r_cnt == CNT_OUT);
         if (r_tick && w_busy) r_overrun <= 1'b1;
         if (w_accept) begin
            r_cnt       <= 3'd1;
            r_phase_acc <= enable ? r_phase_acc + freq_word : '0;
         end else if (w_busy) begin
            r_cnt <= (r_cnt == CNT_LAST) ? 3'd0 : r_cnt + 3'd1;
         end
         if (r_cnt == CNT_OUT) begin
            r_left  <= r_hold_l;
            r_right <= w_scaled;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pl  <= ADDR_W'(r_phase_acc >> (PHASESIZE - ADDR_W));
         r_pr  <= ADDR_W'((r_phase_acc + phase_offset) >> (PHASESIZE - ADDR_W));
         r_amp <= amplitude;
         r_en  <= enable;
      end
      r_addr     <= w_idx;
      r_neg_s0   <= w_q[1];
      r_rom_data <= w_rom[r_addr];
      r_neg_s1   <= r_neg_s0;
      r_sgn      <= r_neg_s1 ? -BITSIZE'(r_rom_data) : BITSIZE'(r_rom_data);
      if (r_cnt == CNT_HOLD) r_hold_l <= w_scaled;
   end

   assign left_chan    = r_left;
   assign right_chan   = r_right;
   assign sample_valid = r_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_sine_dds.sv
// tb_sine_dds: directed and randomized frames against a real-arithmetic sine model with a sample scoreboard.
module tb_sine_dds;

   logic               clk = 1'b0;
   logic               rst;
   logic               lrclk;
   logic               enable;
   logic [23:0]        freq_word;
   logic [23:0]        phase_offset;
   logic [15:0]        amplitude;
   logic signed [15:0] left_chan;
   logic signed [15:0] right_chan;
   logic               sample_valid;
   logic               overrun;

   sine_dds #(.BITSIZE(16), .PHASESIZE(24), .LUTBITS(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .lrclk        (lrclk),
      .enable       (enable),
      .freq_word    (freq_word),
      .phase_offset (phase_offset),
      .amplitude    (amplitude),
      .left_chan    (left_chan),
      .right_chan   (right_chan),
      .sample_valid (sample_valid),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int l;
      int r;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          rom_ref [256];
   exp_t        exp_q [$];
   int          tick_q [$];
   int          busy_until = -100;
   int unsigned m_phase    = 0;
   bit          m_overrun  = 1'b0;
   int          last_l     = 0;
   int          last_r     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected sample from the quarter-wave definition, using real-valued sine and floor scaling
   function automatic int ref_sample(input int unsigned p, input int unsigned amp, input bit en);
      int unsigned q;
      int unsigned idx;
      int          s;
      if (!en) return 0;
      q   = (p >> 22) % 4;
      idx = (p >> 14) % 256;
      if (q == 1 || q == 3) idx = 255 - idx;
      s = (q >= 2) ? -rom_ref[idx] : rom_ref[idx];
      return $rtoi($floor(real'(s) * real'(amp) / 65536.0));
   endfunction

   always @(negedge clk) begin
      bit   ev;
      exp_t e;
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("sample_valid", sample_valid, ev);
      check("overrun", overrun, m_overrun);
      if (ev) begin
         e      = exp_q.pop_front();
         last_l = e.l;
         last_r = e.r;
      end
      if (sample_valid)
         $display("[TB] sample cycle=%0d L=%0d R=%0d (model L=%0d R=%0d)",
                  cyc, left_chan, right_chan, last_l, last_r);
      check("left_chan", left_chan, last_l);
      check("right_chan", right_chan, last_r);
      if (rst) begin
         exp_q.delete();
         tick_q.delete();
         busy_until = -100;
         m_phase    = 0;
         m_overrun  = 1'b0;
         last_l     = 0;
         last_r     = 0;
      end else if (tick_q.size() > 0 && tick_q[0] == cyc) begin
         void'(tick_q.pop_front());
         if (cyc <= busy_until) begin
            m_overrun = 1'b1;
         end else begin
            busy_until = cyc + 6;
            exp_q.push_back(exp_t'{cyc + 6,
               ref_sample(m_phase, amplitude, enable),
               ref_sample((m_phase + phase_offset) % (1 << 24), amplitude, enable)});
            m_phase = enable ? (m_phase + freq_word) % (1 << 24) : 0;
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit en, input int unsigned fw, input int unsigned off,
                         input int unsigned amp);
      enable       = en;
      freq_word    = 24'(fw);
      phase_offset = 24'(off);
      amplitude    = 16'(amp);
   endtask

   // lrclk high for hi clocks then low for lo clocks; tick expected 3 clocks after the rise
   task automatic frame(input int hi, input int lo);
      lrclk = 1'b1;
      tick_q.push_back(cyc + 3);
      wait_clk(hi);
      lrclk = 1'b0;
      wait_clk(lo);
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         rom_ref[i] = $rtoi(32767.0 * $sin(3.141592653589793 * (real'(i) + 0.5) / 512.0) + 0.5);
      rst   = 1'b1;
      lrclk = 1'b0;
      set_in(1'b0, 0, 0, 0);
      wait_clk(5);
      rst = 1'b0;
      wait_clk(3);
      check("reset_left", left_chan, 0);
      check("reset_right", right_chan, 0);
      check("reset_valid", sample_valid, 0);
      check("reset_overrun", overrun, 0);

      // constant output at freq_word 0
      set_in(1'b1, 0, 0, 16'hFFFF);
      for (int i = 0; i < 3; i++) begin
         frame(3, 9);
         check("dc_left", left_chan, 100);
         check("dc_right", right_chan, 100);
      end

      // quarter-turn sweep wraps back to phase 0
      set_in(1'b1, 24'h400000, 0, 16'hFFFF);
      for (int i = 0; i < 5; i++) begin
         frame(3, 9);
         if (i == 0 || i == 4) check("sweep_left_q0", left_chan, 100);
         if (i == 2) check("sweep_left_q2", left_chan, -101);
      end

      // disable zeroes the phase, then half-turn right-channel offset
      set_in(1'b0, 24'h400000, 0, 16'hFFFF);
      frame(3, 9);
      check("dis_left", left_chan, 0);
      set_in(1'b1, 0, 24'h800000, 16'hFFFF);
      frame(3, 9);
      check("offset_left", left_chan, 100);
      check("offset_right", right_chan, -101);
      set_in(1'b1, 0, 24'h800000, 0);
      frame(3, 9);
      check("amp0_left", left_chan, 0);
      check("amp0_right", right_chan, 0);

      // enable drop mid-sweep, then restart from phase 0
      set_in(1'b1, 24'h400000, 0, 16'hFFFF);
      frame(3, 9);
      frame(3, 9);
      set_in(1'b0, 24'h400000, 0, 16'hFFFF);
      frame(3, 9);
      check("off_left", left_chan, 0);
      check("off_right", right_chan, 0);
      set_in(1'b1, 24'h400000, 0, 16'hFFFF);
      frame(3, 9);
      check("reen_left", left_chan, 100);

      // reset held 4 clocks while a sample is in flight
      set_in(1'b1, 24'h123456, 0, 16'hFFFF);
      frame(3, 9);
      lrclk = 1'b1;
      tick_q.push_back(cyc + 3);
      wait_clk(6);
      rst = 1'b1;
      wait_clk(4);
      rst   = 1'b0;
      lrclk = 1'b0;
      wait_clk(10);
      check("midrst_left", left_chan, 0);
      check("midrst_right", right_chan, 0);
      check("midrst_overrun", overrun, 0);
      set_in(1'b1, 24'h400000, 0, 16'hFFFF);
      frame(3, 9);
      check("postrst_left", left_chan, 100);

      // two frame-clock rises 4 clocks apart
      frame(2, 2);
      frame(2, 12);
      check("overrun_set", overrun, 1);
      frame(3, 9);
      check("overrun_sticky", overrun, 1);

      // randomized frames, including short periods and mid-frame input changes
      for (int i = 0; i < 80; i++) begin
         set_in($urandom_range(0, 5) != 0, $urandom, $urandom, $urandom);
         lrclk = 1'b1;
         tick_q.push_back(cyc + 3);
         wait_clk($urandom_range(2, 4));
         if ($urandom_range(0, 3) == 0) set_in($urandom_range(0, 5) != 0, $urandom, $urandom, $urandom);
         lrclk = 1'b0;
         wait_clk($urandom_range(2, 12));
      end

      wait_clk(15);
      check("drain_pending", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
